// File: rtl/usart_pkg.sv
// Shared types and defaults for the USART receive path.
package usart_pkg;

  typedef enum logic {
    RX_FIFO_IDLE,
    RX_FIFO_WAIT_CLEAR
  } rx_fifo_state_t;

  localparam int RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/fifo_sync.sv
// Generic single-clock first-word-fall-through FIFO.
// Count is tracked separately so full and empty never alias.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       comm_clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (do_pop && !do_push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge comm_clock) begin
    if (do_push)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  assign data_out = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/usart_rx_fifo.sv
// Receive buffer behind usart_rx: available/acknowledge drain into a FWFT FIFO.
// Define USART_RX_FIFO_ERROR_FLAG_EN to store framing errors with each byte.
module usart_rx_fifo
  import usart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH
) (
  input  logic                       comm_clock,
  input  logic                       reset_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_available,
  input  logic                       rx_error,
  output logic                       rx_acknowledge,
  input  logic                       pop,
  output logic [7:0]                 data_out,
`ifdef USART_RX_FIFO_ERROR_FLAG_EN
  output logic                       data_error,
`endif
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clear_overflow
);

`ifdef USART_RX_FIFO_ERROR_FLAG_EN
  localparam int WIDTH = 9;
`else
  localparam int WIDTH = 8;
`endif

  rx_fifo_state_t   state;
  logic             take;
  logic             keep;
  logic             push_req;
  logic             pop_ok;
  logic             drop;
  logic [WIDTH-1:0] entry;
  logic [WIDTH-1:0] head;

  assign take = (state == RX_FIFO_IDLE) && rx_available;

`ifdef USART_RX_FIFO_ERROR_FLAG_EN
  assign keep       = 1'b1;
  assign entry      = {rx_error, rx_data};
  assign data_out   = head[7:0];
  assign data_error = head[8];
`else
  // Errored bytes are acknowledged but never stored.
  assign keep     = !rx_error;
  assign entry    = rx_data;
  assign data_out = head;
`endif

  assign push_req = take && keep;
  assign pop_ok   = pop && !empty;
  assign drop     = push_req && full && !pop_ok;

  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RX_FIFO_IDLE;
      rx_acknowledge <= 1'b0;
    end else begin
      unique case (state)
        RX_FIFO_IDLE: begin
          if (rx_available) begin
            state          <= RX_FIFO_WAIT_CLEAR;
            rx_acknowledge <= 1'b1;
          end
        end
        RX_FIFO_WAIT_CLEAR: begin
          if (!rx_available) begin
            state          <= RX_FIFO_IDLE;
            rx_acknowledge <= 1'b0;
          end
        end
        default: begin
          state          <= RX_FIFO_IDLE;
          rx_acknowledge <= 1'b0;
        end
      endcase
    end
  end

  // A drop on the clearing edge keeps the flag set.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clear_overflow)
      overflow <= 1'b0;
  end

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .comm_clock (comm_clock),
    .reset_n    (reset_n),
    .push       (push_req),
    .data_in    (entry),
    .pop        (pop),
    .data_out   (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Directed scoreboard bench for usart_rx_fifo (DEPTH = 16).
module tb_usart_rx_fifo;

  logic       comm_clock = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_available;
  logic       rx_error;
  logic       rx_acknowledge;
  logic       pop;
  logic [7:0] data_out;
`ifdef USART_RX_FIFO_ERROR_FLAG_EN
  logic       data_error;
`endif
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       clear_overflow;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb [$];

  always #5 comm_clock = ~comm_clock;

  usart_rx_fifo #(.DEPTH(16)) dut (
    .comm_clock     (comm_clock),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_available   (rx_available),
    .rx_error       (rx_error),
    .rx_acknowledge (rx_acknowledge),
    .pop            (pop),
    .data_out       (data_out),
`ifdef USART_RX_FIFO_ERROR_FLAG_EN
    .data_error     (data_error),
`endif
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge comm_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Receiver model: raise available, clear it 2 cycles after acknowledge.
  task automatic send(input logic [7:0] b, input logic err,
                      input logic stored);
    int n;
    rx_data      = b;
    rx_error     = err;
    rx_available = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rx_acknowledge && n < 20);
    chk("ack_rise", {31'd0, rx_acknowledge}, 32'd1);
    if (stored) sb.push_back({err, b});
    tick(2);
    rx_available = 1'b0;
    rx_error     = 1'b0;
    tick();
    chk("ack_fall", {31'd0, rx_acknowledge}, 32'd0);
  endtask

  task automatic pop_check(input string tag);
    logic [8:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(tag, {24'd0, data_out}, {24'd0, e[7:0]});
`ifdef USART_RX_FIFO_ERROR_FLAG_EN
      chk({tag, "_err"}, {31'd0, data_error}, {31'd0, e[8]});
`endif
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    rx_data = '0;
    rx_available = 1'b0;
    rx_error = 1'b0;
    pop = 1'b0;
    clear_overflow = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_ack", {31'd0, rx_acknowledge}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);

    // Single byte
    send(8'h41, 1'b0, 1'b1);
    chk("single_count", {27'd0, count}, 32'd1);
    chk("single_empty", {31'd0, empty}, 32'd0);
    pop_check("single_data");
    chk("single_drained", {31'd0, empty}, 32'd1);

    // Pop on empty must not underflow
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pop_empty_count", {27'd0, count}, 32'd0);
    chk("pop_empty_flag", {31'd0, empty}, 32'd1);

    // Fill, then overflow
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b1);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_count", {27'd0, count}, 32'd16);
    chk("fill_ovf", {31'd0, overflow}, 32'd0);
    send(8'h55, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {27'd0, count}, 32'd16);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_clear", {31'd0, overflow}, 32'd0);

    // Concurrent push and pop while full
    chk("cc_head", {24'd0, data_out}, {24'd0, sb[0][7:0]});
    void'(sb.pop_front());
    rx_data = 8'h77;
    rx_available = 1'b1;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    sb.push_back({1'b0, 8'h77});
    chk("cc_ack", {31'd0, rx_acknowledge}, 32'd1);
    chk("cc_count", {27'd0, count}, 32'd16);
    chk("cc_ovf", {31'd0, overflow}, 32'd0);
    chk("cc_next_head", {24'd0, data_out}, 32'h01);
    tick(2);
    rx_available = 1'b0;
    tick();
    chk("cc_ack_fall", {31'd0, rx_acknowledge}, 32'd0);
    for (int i = 0; i < 16; i++) pop_check("drain");
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_count", {27'd0, count}, 32'd0);

    // Errored byte
`ifdef USART_RX_FIFO_ERROR_FLAG_EN
    send(8'hAA, 1'b1, 1'b1);
    chk("err_count", {27'd0, count}, 32'd1);
    chk("err_flag", {31'd0, data_error}, 32'd1);
    pop_check("err_data");
`else
    send(8'hAA, 1'b1, 1'b0);
    chk("err_dropped", {31'd0, empty}, 32'd1);
`endif
    chk("err_no_ovf", {31'd0, overflow}, 32'd0);

    // Stuck available captures exactly once
    rx_data = 8'h33;
    rx_available = 1'b1;
    tick(10);
    sb.push_back({1'b0, 8'h33});
    chk("stuck_ack", {31'd0, rx_acknowledge}, 32'd1);
    rx_available = 1'b0;
    tick(2);
    chk("stuck_count", {27'd0, count}, 32'd1);
    pop_check("stuck_data");

    // Reset while in WAIT_CLEAR
    send(8'h12, 1'b0, 1'b1);
    rx_data = 8'h34;
    rx_available = 1'b1;
    tick();
    chk("mid_ack_hi", {31'd0, rx_acknowledge}, 32'd1);
    chk("mid_count_hi", {27'd0, count}, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_ack_lo", {31'd0, rx_acknowledge}, 32'd0);
    chk("mid_count_lo", {27'd0, count}, 32'd0);
    chk("mid_empty", {31'd0, empty}, 32'd1);
    sb.delete();
    rx_available = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick();
    send(8'h5A, 1'b0, 1'b1);
    pop_check("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
